// File: rtl/reshape_hls_dl_pkg.sv
// Shared types and helpers for the Reshape HLS deadlock-report sequencer.
package reshape_hls_dl_pkg;

   localparam int unsigned CNT_W        = 16;
   localparam int unsigned MAX_PROC_NUM = 64;

   typedef enum logic [2:0] {
      StIdle,
      StConfirm,
      StOrigin,
      StTrace,
      StReport,
      StClear
   } dl_state_e;

   // Callers size-cast the result down to their PROC_NUM width.
   function automatic logic [MAX_PROC_NUM-1:0] onehot(input int unsigned idx);
      onehot = {{(MAX_PROC_NUM-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/reshape_hls_rr_pick.sv
// Combinational round-robin search: first set request at or after start_i, wrapping to 0.
module reshape_hls_rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             hi_found;
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] lo_idx;

   // Descending scan: the last hit kept is the lowest index in each half.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            lo_idx = IDX_W'(i);
            if (IDX_W'(i) >= start_i) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
         end
      end
   end

   assign valid_o = |req_i;
   assign idx_o   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/reshape_hls_deadlock_report_ctrl.sv
// Central deadlock-report sequencer: arbitrates detect flags, injects the origin token,
// waits for its return and raises a held report or retires stale tokens.
module reshape_hls_deadlock_report_ctrl
   import reshape_hls_dl_pkg::*;
#(
   parameter int unsigned PROC_NUM       = 4,
   parameter int unsigned ID_W           = 2,
   parameter int unsigned CONFIRM_CYCLES = 8,
   parameter int unsigned TRACE_TIMEOUT  = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [PROC_NUM-1:0] dl_detect_vec,
   input  logic [PROC_NUM-1:0] token_return_vec,
   output logic [PROC_NUM-1:0] origin_vec,
   output logic [PROC_NUM-1:0] token_clear_vec,
   output logic                dl_report,
   output logic [ID_W-1:0]     dl_proc_id,
   input  logic                dl_report_ack,
   output logic                busy
);

   dl_state_e           state_q, state_d;
   logic [ID_W-1:0]     sel_q, sel_d;
   logic [ID_W-1:0]     rr_q, rr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PROC_NUM-1:0] origin_q, origin_d;
   logic [PROC_NUM-1:0] clear_q, clear_d;
   logic                report_q, report_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                busy_q, busy_d;

   logic                pick_valid;
   logic [ID_W-1:0]     pick_idx;
   logic [PROC_NUM-1:0] oh_sel;
   logic                det_sel;
   logic                ret_sel;
   logic [ID_W-1:0]     next_ptr;
   logic [CNT_W-1:0]    cnt_inc;

   reshape_hls_rr_pick #(
      .N     (PROC_NUM),
      .IDX_W (ID_W)
   ) u_rr_pick (
      .req_i   (dl_detect_vec),
      .start_i (rr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign oh_sel   = PROC_NUM'(onehot(32'(sel_q)));
   assign det_sel  = |(dl_detect_vec & oh_sel);
   assign ret_sel  = |(token_return_vec & oh_sel);
   assign next_ptr = (sel_q == ID_W'(PROC_NUM - 1)) ? '0 : sel_q + ID_W'(1);
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      origin_d = '0;
      clear_d  = '0;
      report_d = 1'b0;
      id_d     = '0;
      unique case (state_q)
         StIdle: begin
            if (enable && pick_valid) begin
               sel_d   = pick_idx;
               cnt_d   = '0;
               state_d = StConfirm;
            end
         end
         StConfirm: begin
            if (!det_sel) begin
               // Nothing injected yet, so no token needs retiring.
               state_d = StIdle;
               rr_d    = next_ptr;
            end else if (cnt_q == CNT_W'(CONFIRM_CYCLES - 1)) begin
               state_d  = StOrigin;
               origin_d = oh_sel;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StOrigin: begin
            cnt_d   = '0;
            state_d = StTrace;
         end
         StTrace: begin
            // A return beats a timeout landing on the same cycle.
            if (ret_sel) begin
               state_d  = StReport;
               clear_d  = oh_sel;
               report_d = 1'b1;
               id_d     = sel_q;
            end else if (cnt_q == CNT_W'(TRACE_TIMEOUT - 1) || !det_sel) begin
               state_d = StClear;
               clear_d = '1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StReport: begin
            if (dl_report_ack) begin
               state_d = StIdle;
               rr_d    = next_ptr;
            end else begin
               report_d = 1'b1;
               id_d     = sel_q;
            end
         end
         StClear: begin
            state_d = StIdle;
            rr_d    = next_ptr;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         rr_q     <= '0;
         cnt_q    <= '0;
         origin_q <= '0;
         clear_q  <= '0;
         report_q <= 1'b0;
         id_q     <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         origin_q <= origin_d;
         clear_q  <= clear_d;
         report_q <= report_d;
         id_q     <= id_d;
         busy_q   <= busy_d;
      end
   end

   assign origin_vec      = origin_q;
   assign token_clear_vec = clear_q;
   assign dl_report       = report_q;
   assign dl_proc_id      = id_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_reshape_hls_deadlock_report_ctrl.sv
// Directed self-checking bench for reshape_hls_deadlock_report_ctrl (PROC_NUM=4).
module tb_reshape_hls_deadlock_report_ctrl;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [3:0] dl_detect_vec;
   logic [3:0] token_return_vec;
   logic [3:0] origin_vec;
   logic [3:0] token_clear_vec;
   logic       dl_report;
   logic [1:0] dl_proc_id;
   logic       dl_report_ack;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   bit bad;

   reshape_hls_deadlock_report_ctrl #(
      .PROC_NUM       (4),
      .ID_W           (2),
      .CONFIRM_CYCLES (8),
      .TRACE_TIMEOUT  (64)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .enable           (enable),
      .dl_detect_vec    (dl_detect_vec),
      .token_return_vec (token_return_vec),
      .origin_vec       (origin_vec),
      .token_clear_vec  (token_clear_vec),
      .dl_report        (dl_report),
      .dl_proc_id       (dl_proc_id),
      .dl_report_ack    (dl_report_ack),
      .busy             (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      enable           = 1'b0;
      dl_detect_vec    = '0;
      token_return_vec = '0;
      dl_report_ack    = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_origin(input string tag, input logic [3:0] exp);
      int n = 0;
      while (origin_vec === 4'b0000 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(origin_vec), 32'(exp));
   endtask

   task automatic wait_report(input string tag, input logic [1:0] exp_id);
      int n = 0;
      while (dl_report !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_report"}, 32'(dl_report), 32'd1);
      chk({tag, "_id"}, 32'(dl_proc_id), 32'(exp_id));
   endtask

   initial begin
      reset            = 1'b1;
      enable           = 1'b0;
      dl_detect_vec    = '0;
      token_return_vec = '0;
      dl_report_ack    = 1'b0;
      tick();
      tick();
      chk("rst_origin", 32'(origin_vec), 32'd0);
      chk("rst_clear", 32'(token_clear_vec), 32'd0);
      chk("rst_report", 32'(dl_report), 32'd0);
      chk("rst_id", 32'(dl_proc_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // Single detect on process 2, token returns 5 cycles after the origin.
      enable        = 1'b1;
      dl_detect_vec = 4'b0100;
      tick();
      chk("t1_busy_sel", 32'(busy), 32'd1);
      chk("t1_no_origin_sel", 32'(origin_vec), 32'd0);
      bad = 1'b0;
      repeat (7) begin
         tick();
         if (origin_vec !== 4'b0000) bad = 1'b1;
      end
      chk("t1_no_early_origin", 32'(bad), 32'd0);
      tick();
      chk("t1_origin", 32'(origin_vec), 32'h4);
      chk("t1_no_clear_origin", 32'(token_clear_vec), 32'd0);
      tick();
      chk("t1_origin_1cyc", 32'(origin_vec), 32'd0);
      repeat (4) tick();
      chk("t1_no_report_yet", 32'(dl_report), 32'd0);
      token_return_vec = 4'b0100;
      tick();
      chk("t1_clear", 32'(token_clear_vec), 32'h4);
      chk("t1_report", 32'(dl_report), 32'd1);
      chk("t1_id", 32'(dl_proc_id), 32'd2);
      token_return_vec = 4'b0000;
      tick();
      chk("t1_clear_1cyc", 32'(token_clear_vec), 32'd0);
      chk("t1_report_held", 32'(dl_report), 32'd1);
      chk("t1_id_held", 32'(dl_proc_id), 32'd2);
      tick();
      chk("t1_report_held2", 32'(dl_report), 32'd1);
      dl_report_ack = 1'b1;
      dl_detect_vec = 4'b0000;
      tick();
      chk("t1_report_acked", 32'(dl_report), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);
      dl_report_ack = 1'b0;

      // Round-robin fairness between processes 0 and 3.
      do_reset();
      enable           = 1'b1;
      dl_detect_vec    = 4'b1001;
      token_return_vec = 4'b1001;
      for (int r = 0; r < 4; r++) begin
         wait_report($sformatf("t2_rr%0d", r), (r % 2 == 0) ? 2'd0 : 2'd3);
         tick();
         dl_report_ack = 1'b1;
         tick();
         dl_report_ack = 1'b0;
         if (r == 3) begin
            dl_detect_vec    = 4'b0000;
            token_return_vec = 4'b0000;
         end
      end

      // False alarm in CONFIRM: detect 1 high for 3 cycles only.
      do_reset();
      enable        = 1'b1;
      dl_detect_vec = 4'b0010;
      bad           = 1'b0;
      tick();
      chk("t3_busy_sel", 32'(busy), 32'd1);
      repeat (2) begin
         tick();
         if (origin_vec !== 4'b0000 || token_clear_vec !== 4'b0000) bad = 1'b1;
      end
      dl_detect_vec = 4'b0000;
      tick();
      if (origin_vec !== 4'b0000 || token_clear_vec !== 4'b0000) bad = 1'b1;
      chk("t3_busy_drop", 32'(busy), 32'd0);
      tick();
      if (origin_vec !== 4'b0000 || token_clear_vec !== 4'b0000) bad = 1'b1;
      chk("t3_no_pulses", 32'(bad), 32'd0);
      dl_detect_vec    = 4'b0110;
      token_return_vec = 4'b1111;
      wait_origin("t3_origin_from2", 4'b0100);
      wait_report("t3_next", 2'd2);
      tick();
      dl_report_ack    = 1'b1;
      dl_detect_vec    = 4'b0000;
      token_return_vec = 4'b0000;
      tick();
      dl_report_ack = 1'b0;

      // Trace timeout: no token ever returns.
      do_reset();
      enable        = 1'b1;
      dl_detect_vec = 4'b0001;
      wait_origin("t4_origin", 4'b0001);
      bad = 1'b0;
      repeat (64) begin
         tick();
         if (token_clear_vec !== 4'b0000 || dl_report !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      chk("t4_trace_window", 32'(bad), 32'd0);
      tick();
      chk("t4_clear_all", 32'(token_clear_vec), 32'hf);
      chk("t4_no_report", 32'(dl_report), 32'd0);
      chk("t4_busy_in_clear", 32'(busy), 32'd1);
      dl_detect_vec = 4'b0000;
      tick();
      chk("t4_busy_drop", 32'(busy), 32'd0);
      chk("t4_clear_1cyc", 32'(token_clear_vec), 32'd0);

      // Return and timeout on the same (last) TRACE cycle, ack already high.
      do_reset();
      enable        = 1'b1;
      dl_detect_vec = 4'b0001;
      wait_origin("t5_origin", 4'b0001);
      repeat (64) tick();
      chk("t5_still_trace", 32'(busy), 32'd1);
      chk("t5_no_clear_yet", 32'(token_clear_vec), 32'd0);
      token_return_vec = 4'b0001;
      dl_report_ack    = 1'b1;
      tick();
      chk("t5_report_wins", 32'(dl_report), 32'd1);
      chk("t5_clear_onehot", 32'(token_clear_vec), 32'h1);
      dl_detect_vec    = 4'b0000;
      token_return_vec = 4'b0000;
      tick();
      chk("t5_report_1cyc", 32'(dl_report), 32'd0);
      chk("t5_idle", 32'(busy), 32'd0);
      dl_report_ack = 1'b0;

      // Asynchronous reset during the origin pulse and during TRACE.
      do_reset();
      enable        = 1'b1;
      dl_detect_vec = 4'b0100;
      wait_origin("t6_origin", 4'b0100);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_origin", 32'(origin_vec), 32'd0);
      chk("t6_rst_busy_o", 32'(busy), 32'd0);
      #1 reset = 1'b0;
      wait_origin("t6_origin2", 4'b0100);
      tick();
      chk("t6_trace_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_busy_t", 32'(busy), 32'd0);
      chk("t6_rst_origin_t", 32'(origin_vec), 32'd0);
      chk("t6_rst_clear_t", 32'(token_clear_vec), 32'd0);
      chk("t6_rst_report_t", 32'(dl_report), 32'd0);
      enable        = 1'b0;
      dl_detect_vec = 4'b1111;
      tick();
      reset = 1'b0;
      bad   = 1'b0;
      repeat (12) begin
         tick();
         if (busy !== 1'b0 || origin_vec !== 4'b0000) bad = 1'b1;
      end
      chk("t6_no_arb_disabled", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
